// File: rtl/dna_match_engine.sv
// Streaming nucleotide pattern matcher: counts (overlapping) occurrences of a
// configured pattern in a 2-bit symbol stream and records the first hit position.
module dna_match_engine #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [2*MAX_LEN-1:0]   cfg_pattern,
  input  logic [4:0]             cfg_len,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   clear,
  input  logic [1:0]             s_sym,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   irq,
  output logic                   err,
  output logic [CNT_W-1:0]       match_count,
  output logic [CNT_W-1:0]       first_pos,
  output logic [CNT_W-1:0]       sym_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2*MAX_LEN-1:0]    pat_q, pat_d;
  logic [2*MAX_LEN-3:0]    win_q, win_d;
  logic [4:0]              len_q, len_d;
  logic [CNT_W-1:0]        mcnt_q, mcnt_d;
  logic [CNT_W-1:0]        fpos_q, fpos_d;
  logic [CNT_W-1:0]        scnt_q, scnt_d;
  logic                    found_q, found_d;
  logic                    err_q, err_d;
  logic                    irq_q, irq_d;

  logic                    len_ok_s;
  logic                    accept_s;
  logic                    hit_s;
  logic [2*MAX_LEN-1:0]    win_shift_s;
  logic [CNT_W-1:0]        scnt_inc_s;

  assign len_ok_s    = (cfg_len != 5'd0) && (32'(cfg_len) <= 32'(MAX_LEN));
  assign accept_s    = s_valid && (state_q == ST_RUN);
  // Newest symbol sits at bits [1:0]; symbol j acceptances older sits at [2j+1:2j].
  assign win_shift_s = {win_q, s_sym};
  assign scnt_inc_s  = (scnt_q == {CNT_W{1'b1}}) ? scnt_q : scnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks a coincident final symbol
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && len_ok_s) state_d = ST_RUN;
        else                   state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (abort)                    state_d = ST_IDLE;
        else if (accept_s && s_last)  state_d = ST_DONE;
        else                          state_d = ST_RUN;
      end
      ST_DONE: begin
        if (clear) state_d = ST_IDLE;
        else       state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the state and result registers
  always_comb begin
    s_ready     = (state_q == ST_RUN);
    busy        = (state_q == ST_RUN);
    done        = (state_q == ST_DONE);
    irq         = irq_q;
    err         = err_q;
    match_count = mcnt_q;
    first_pos   = fpos_q;
    sym_count   = scnt_q;
  end

  // Pattern compare: pattern symbol k against the symbol L-1-k acceptances back
  always_comb begin
    hit_s = (len_q != 5'd0) && (32'(scnt_inc_s) >= 32'(len_q));
    for (int j = 0; j < MAX_LEN; j++) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if (((j + k + 1) == int'(len_q)) && (pat_q[2*k +: 2] != win_shift_s[2*j +: 2])) begin
          hit_s = 1'b0;
        end else begin
          hit_s = hit_s;
        end
      end
    end
  end

  // Datapath next-state: configuration latch, window, counters, flags
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    win_d   = win_q;
    mcnt_d  = mcnt_q;
    fpos_d  = fpos_q;
    scnt_d  = scnt_q;
    found_d = found_q;
    err_d   = err_q;
    irq_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && len_ok_s) begin
          pat_d   = cfg_pattern;
          len_d   = cfg_len;
          win_d   = '0;
          mcnt_d  = '0;
          scnt_d  = '0;
          fpos_d  = '1;
          found_d = 1'b0;
          err_d   = 1'b0;
        end else if (start) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          win_d  = win_shift_s[2*MAX_LEN-3:0];
          scnt_d = scnt_inc_s;
          if (hit_s) begin
            mcnt_d = (mcnt_q == {CNT_W{1'b1}}) ? mcnt_q : mcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (!found_q) begin
              fpos_d  = scnt_q - CNT_W'(len_q) + {{(CNT_W-1){1'b0}}, 1'b1};
              found_d = 1'b1;
            end else begin
              found_d = 1'b1;
            end
          end else begin
            mcnt_d = mcnt_q;
          end
          irq_d = s_last && !abort;
        end else begin
          irq_d = 1'b0;
        end
      end
      ST_DONE: begin
        irq_d = 1'b0;
      end
      default: begin
        irq_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pat_q   <= '0;
      len_q   <= 5'd0;
      win_q   <= '0;
      mcnt_q  <= '0;
      fpos_q  <= '1;
      scnt_q  <= '0;
      found_q <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      win_q   <= win_d;
      mcnt_q  <= mcnt_d;
      fpos_q  <= fpos_d;
      scnt_q  <= scnt_d;
      found_q <= found_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_dna_match_engine.sv
// Self-checking bench for dna_match_engine: directed scenarios plus randomized
// streams compared against a queue-based behavioural model.
module tb_dna_match_engine;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic [31:0] cfg_pattern = 32'd0;
  logic [4:0]  cfg_len = 5'd0;
  logic        start = 1'b0, abort = 1'b0, clear = 1'b0;
  logic [1:0]  s_sym = 2'd0;
  logic        s_valid = 1'b0, s_last = 1'b0;

  logic        s_ready, busy, done, irq, err;
  logic [15:0] match_count, first_pos, sym_count;
  logic        s_ready4, busy4, done4, irq4, err4;
  logic [3:0]  match_count4, first_pos4, sym_count4;

  int n_vec = 0;
  int n_err = 0;
  int irq_seen = 0;

  // Behavioural model state
  int          m_st;      // 0 idle, 1 run, 2 done
  int          m_len;
  logic [31:0] m_pat;
  int          m_q[$];
  int          m_mc, m_sc;
  logic [15:0] m_fp;
  bit          m_found, m_err, m_irq;

  always #5 ACLK = ~ACLK;

  dna_match_engine #(.MAX_LEN(16), .CNT_W(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .start(start), .abort(abort), .clear(clear), .s_sym(s_sym), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .busy(busy), .done(done), .irq(irq), .err(err),
    .match_count(match_count), .first_pos(first_pos), .sym_count(sym_count)
  );

  dna_match_engine #(.MAX_LEN(16), .CNT_W(4)) dut4 (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .start(start), .abort(abort), .clear(clear), .s_sym(s_sym), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready4), .busy(busy4), .done(done4), .irq(irq4), .err(err4),
    .match_count(match_count4), .first_pos(first_pos4), .sym_count(sym_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_len = 0; m_pat = 32'd0; m_q.delete();
    m_mc = 0; m_sc = 0; m_fp = 16'hFFFF; m_found = 1'b0; m_err = 1'b0; m_irq = 1'b0;
  endtask

  // Apply the rules to the inputs present before the coming edge
  task automatic model_step();
    bit hit;
    int n;
    m_irq = 1'b0;
    if (m_st == 0) begin
      if (start) begin
        if (cfg_len >= 5'd1 && cfg_len <= 5'd16) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_q.delete();
          m_mc = 0; m_sc = 0; m_fp = 16'hFFFF; m_found = 1'b0; m_err = 1'b0; m_st = 1;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_st == 1) begin
      if (s_valid) begin
        m_q.push_back(int'(s_sym));
        if (m_sc < 65535) m_sc++;
        n = m_q.size();
        hit = (m_sc >= m_len);
        for (int k = 0; k < m_len && hit; k++)
          if (int'(m_pat[2*k +: 2]) != m_q[n - m_len + k]) hit = 1'b0;
        if (hit) begin
          if (m_mc < 65535) m_mc++;
          if (!m_found) begin m_fp = 16'(n - m_len); m_found = 1'b1; end
        end
      end
      if (abort) m_st = 0;
      else if (s_valid && s_last) begin m_st = 2; m_irq = 1'b1; end
    end else begin
      if (clear) m_st = 0;
    end
  endtask

  task automatic compare_all();
    check("s_ready",     32'(s_ready),     32'(m_st == 1));
    check("busy",        32'(busy),        32'(m_st == 1));
    check("done",        32'(done),        32'(m_st == 2));
    check("irq",         32'(irq),         32'(m_irq));
    check("err",         32'(err),         32'(m_err));
    check("match_count", 32'(match_count), 32'(m_mc));
    check("first_pos",   32'(first_pos),   32'(m_fp));
    check("sym_count",   32'(sym_count),   32'(m_sc));
  endtask

  task automatic cyc();
    model_step();
    @(posedge ACLK); #1;
    compare_all();
    if (irq) irq_seen++;
    start = 1'b0; abort = 1'b0; clear = 1'b0; s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] pat, input logic [4:0] len);
    cfg_pattern = pat; cfg_len = len; start = 1'b1;
    cyc();
  endtask

  task automatic send(input logic [1:0] sym, input bit last, input bit ab);
    s_valid = 1'b1; s_sym = sym; s_last = last; abort = ab;
    cyc();
  endtask

  initial begin
    int len, n;
    bit aborted;
    logic [1:0] acg [6];
    acg = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    #1 ARESET = 1'b1;
    #2;
    model_reset();
    compare_all();
    check("rst_sym_count4", 32'(sym_count4), 32'd0);
    @(posedge ACLK); #1 ARESET = 1'b0;

    // ACG over 0,1,2,0,1,2
    irq_seen = 0;
    do_start(32'h24, 5'd3);
    for (int i = 0; i < 6; i++) send(acg[i], i == 5, 1'b0);
    cyc();
    check("acg_match_count", 32'(match_count), 32'd2);
    check("acg_first_pos",   32'(first_pos),   32'd0);
    check("acg_sym_count",   32'(sym_count),   32'd6);
    check("acg_irq_pulses",  32'(irq_seen),    32'd1);
    clear = 1'b1; cyc();

    // AA with gaps in s_valid
    do_start(32'h0, 5'd2);
    for (int i = 0; i < 4; i++) begin cyc(); send(2'd0, i == 3, 1'b0); end
    check("aa_match_count", 32'(match_count), 32'd3);
    check("aa_first_pos",   32'(first_pos),   32'd0);
    clear = 1'b1; cyc();

    // Illegal lengths, then a legal start clears err
    do_start(32'h0, 5'd0);
    do_start(32'h0, 5'd17);
    check("badlen_err",  32'(err),  32'd1);
    check("badlen_busy", 32'(busy), 32'd0);
    do_start(32'h5, 5'd2);
    check("goodlen_err",  32'(err),  32'd0);
    check("goodlen_busy", 32'(busy), 32'd1);
    abort = 1'b1; cyc();

    // Saturation on the 4-bit instance
    do_start(32'h0, 5'd1);
    for (int i = 0; i < 20; i++) send(2'd0, i == 19, 1'b0);
    check("sat_match_count4", 32'(match_count4), 32'd15);
    check("sat_sym_count4",   32'(sym_count4),   32'd15);
    check("sat_first_pos4",   32'(first_pos4),   32'd0);
    check("sat_done4",        32'(done4),        32'd1);
    check("sat_match_count",  32'(match_count),  32'd20);
    clear = 1'b1; cyc();

    // Abort on the 4th acceptance of T,T,A,C,G
    irq_seen = 0;
    do_start(32'h24, 5'd3);
    send(2'd3, 1'b0, 1'b0); send(2'd3, 1'b0, 1'b0); send(2'd0, 1'b0, 1'b0);
    send(2'd1, 1'b0, 1'b1);
    cyc(); cyc();
    check("abort_sym_count", 32'(sym_count), 32'd4);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_done",      32'(done),      32'd0);
    check("abort_irq",       32'(irq_seen),  32'd0);

    // Asynchronous reset in the middle of a run, then start on the first edge
    do_start(32'h0, 5'd1);
    send(2'd0, 1'b0, 1'b0); send(2'd0, 1'b0, 1'b0);
    #2 ARESET = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("arst_first_pos4", 32'(first_pos4), 32'hF);
    #1 ARESET = 1'b0;
    do_start(32'h1, 5'd1);
    check("post_rst_busy", 32'(busy), 32'd1);
    abort = 1'b1; cyc();

    // Abort together with an accepted last symbol
    irq_seen = 0;
    do_start(32'h4, 5'd2);
    send(2'd0, 1'b0, 1'b0);
    send(2'd1, 1'b1, 1'b1);
    cyc(); cyc();
    check("abl_sym_count",   32'(sym_count),   32'd2);
    check("abl_match_count", 32'(match_count), 32'd1);
    check("abl_done",        32'(done),        32'd0);
    check("abl_irq",         32'(irq_seen),    32'd0);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(1, 3)) begin
        s_valid = 1'($urandom_range(0, 1));
        s_sym   = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0) begin
          start   = 1'b1;
          cfg_len = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
        end
        cyc();
      end
      len = $urandom_range(1, 4);
      do_start($urandom, 5'(len));
      n = $urandom_range(15, 40);
      aborted = 1'b0;
      for (int i = 0; i < n && !aborted; i++) begin
        s_valid = ($urandom_range(0, 3) != 0) || (i == n - 1);
        s_sym   = 2'($urandom_range(0, 3));
        s_last  = (i == n - 1);
        if ($urandom_range(0, 49) == 0) begin abort = 1'b1; aborted = 1'b1; end
        if ($urandom_range(0, 9) == 0) begin start = 1'b1; cfg_len = 5'd2; end
        cyc();
      end
      if (!aborted) begin
        repeat (2) begin
          s_valid = 1'b1;
          start   = 1'($urandom_range(0, 1));
          cyc();
        end
        clear = 1'b1; cyc();
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dna_match_engine.md
DNA_MATCH_ENGINE -- requirements
Module: dna_match_engine

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning maximum pattern length in nucleotides (2..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the match, position and symbol counters.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic is rising-edge ACLK.
REQ-004 SHALL have port ARESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cfg_pattern, input, 2*MAX_LEN, pattern (symbol k at bits [2k+1:2k]; A=0, C=1, G=2, T=3).
REQ-006 SHALL have port cfg_len, input, 5, pattern length in symbols.
REQ-007 SHALL have port start, input, 1, single-cycle start pulse from the register file.
REQ-008 SHALL have port abort, input, 1, single-cycle abort pulse.
REQ-009 SHALL have port clear, input, 1, single-cycle pulse that returns DONE to IDLE.
REQ-010 SHALL have port s_sym, input, 2, stream nucleotide.
REQ-011 SHALL have port s_valid, input, 1, stream symbol valid.
REQ-012 SHALL have port s_last, input, 1, final symbol of stream.
REQ-013 SHALL have port s_ready, output, 1, engine accepts a symbol.
REQ-014 SHALL have port busy, output, 1, high in RUN.
REQ-015 SHALL have port done, output, 1, high in DONE.
REQ-016 SHALL have port irq, output, 1, one-cycle pulse on entry to DONE.
REQ-017 SHALL have port err, output, 1, sticky bad-length flag.
REQ-018 SHALL have port match_count, output, CNT_W, number of matches found.
REQ-019 SHALL have port first_pos, output, CNT_W, 0-based stream index of first symbol of the first match.
REQ-020 SHALL have port sym_count, output, CNT_W, number of symbols accepted.

Function
REQ-021 SHALL implement states IDLE, RUN, DONE; reset state IDLE.
REQ-022 IDLE: start with 1<=cfg_len<=MAX_LEN SHALL latch cfg_pattern/cfg_len, clear match_count, sym_count, window and err, set first_pos to all-ones, and enter RUN next cycle.
REQ-023 IDLE: start with cfg_len of 0 or >MAX_LEN SHALL set err=1 and remain in IDLE, with counters unchanged.
REQ-024 s_ready SHALL equal 1 exactly while in RUN; a symbol is accepted on cycles where s_valid and s_ready are both high.
REQ-025 On acceptance SHALL shift s_sym into the window and increment sym_count (saturating at 2^CNT_W-1).
REQ-026 Match SHALL be declared on an accepted symbol when sym_count (including this symbol) >= L and, for every k<L, pattern symbol k equals the symbol accepted L-1-k acceptances before this one; overlapping matches each count.
REQ-027 match_count SHALL increment, saturating at 2^CNT_W-1, and be visible the cycle after the matching acceptance.
REQ-028 On the first match SHALL set first_pos = (index of the accepted symbol) - L + 1; later matches SHALL NOT change it.
REQ-029 Acceptance with s_last=1 SHALL be fully processed, then enter DONE next cycle with irq=1 for exactly that cycle.
REQ-030 start in RUN or DONE SHALL be ignored; abort in RUN SHALL go to IDLE next cycle, with no done and no irq, and with counters held.
REQ-031 abort in the same cycle as an accepted s_last SHALL take priority: the symbol is counted, the next state is IDLE, and no irq is raised.
REQ-032 clear in DONE SHALL go to IDLE; results SHALL hold until the next valid start.
REQ-033 s_valid outside RUN SHALL be ignored.

Reset
REQ-034 ARESET high SHALL immediately force IDLE and set s_ready=0, busy=0, done=0, irq=0, err=0, match_count=0, sym_count=0, first_pos=all-ones, and window=0, including mid-RUN.
REQ-035 After ARESET falls, the engine SHALL accept start on the first rising ACLK edge.

Verification
REQ-036 cfg_pattern=0x24 (ACG), len=3, stream 0,1,2,0,1,2 with last on the 6th symbol -> match_count=2, first_pos=0, sym_count=6, one irq pulse.
REQ-037 pattern AA (0x0), len=2, stream A,A,A,A with gaps in s_valid -> match_count=3 (overlap), first_pos=0.
REQ-038 start with cfg_len=0, then with cfg_len=17 -> err=1, busy stays 0; a following valid start clears err.
REQ-039 CNT_W=4, pattern A, len=1, 20 A's -> match_count=15, sym_count=15 (saturated).
REQ-040 pattern ACG, stream T,T,A,C,G; abort on the 4th acceptance -> IDLE, no irq, sym_count=4; in a separate run, ARESET mid-RUN -> all outputs at reset values asynchronously.
REQ-041 Abort coincident with an accepted s_last -> IDLE, irq never asserted, sym_count includes the last symbol.
